// File: rtl/cmp_flags_unit.sv
// cmp_flags_unit: ALU flag register {S,C,O,Z} with branch-condition decode and a LIFO of saved flag words
// Signed conditions on cond_sel 11-14 exist only when CMP_SIGNED_COND_EN is defined.
module cmp_flags_unit #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  input  logic             overflow,
  input  logic             carry,
  input  logic             flag_we,
  input  logic             flags_wr,
  input  logic [3:0]       flags_wdata,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  input  logic [3:0]       cond_sel,
  output logic             cond_true,
  output logic [3:0]       flags_out,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);
  localparam int PW = $clog2(STACK_DEPTH + 1);
  logic [3:0]    flags_q, flags_d;
  logic [PW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic [3:0]    mem_q [STACK_DEPTH];
  logic [PW-1:0] top_idx, wr_idx;
  logic          full, empty, do_pop, do_swap, do_push, mem_we;
  logic [3:0]    cap;
  logic [15:0]   conds;
  always_comb begin
    full    = depth_q == PW'(STACK_DEPTH);
    empty   = depth_q == '0;
    top_idx = depth_q - PW'(1);
    do_pop  = pop & ~empty;
    do_swap = do_pop & push;
    do_push = push & ~pop & ~full;
    mem_we  = do_push | do_swap;
    wr_idx  = do_swap ? top_idx : depth_q;
    cap     = {result[WIDTH-1], carry, overflow, ~|result};
    flags_d = do_pop ? mem_q[top_idx] : flags_wr ? flags_wdata : flag_we ? cap : flags_q;
    depth_d = do_swap ? depth_q : do_pop ? top_idx : do_push ? depth_q + PW'(1) : depth_q;
    err_d   = (push & ~pop & full) | (pop & empty) | (err_q & ~err_clr);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  always_ff @(posedge clk)
    if (mem_we) mem_q[wr_idx] <= flags_q;
  logic s, c, o, z;
  always_comb begin
    {s, c, o, z} = flags_q;
    conds = {1'b0,
`ifdef CMP_SIGNED_COND_EN
             z | (s ^ o), ~z & ~(s ^ o), s ^ o, ~(s ^ o),
`else
             4'b0000,
`endif
             ~c | z, c & ~z, ~o, o, ~s, s, ~c, c, ~z, z, 1'b1};
    cond_true = conds[cond_sel];
  end
  assign flags_out   = flags_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;
endmodule
